// File: rtl/dict_pkg.sv
// dict_pkg: shared dictionary field widths and the loader state encoding
package dict_pkg;

    localparam int KEY_WIDTH  = 6;
    localparam int VAL_WIDTH  = 12;
    localparam int ADDR_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_BURST,
        S_ABORT,
        S_DONE,
        S_ERROR
    } state_t;

endpackage

// File: rtl/dict_prefetch_fifo.sv
// dict_prefetch_fifo: small synchronous FIFO with flush, head is read combinationally
module dict_prefetch_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_din,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [CW-1:0] r_count;
    logic          w_pop;

    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

    // pointers and occupancy; flush drops everything including a same-cycle push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(w_pop);
        end
    end

    // storage needs no reset, validity is tracked by the count
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr] <= i_din;
    end

endmodule

// File: rtl/dict_loader.sv
// dict_loader: fetches the dictionary image from boot memory and writes it as one unbroken burst
module dict_loader #(
    parameter int KEY_WIDTH  = dict_pkg::KEY_WIDTH,
    parameter int VAL_WIDTH  = dict_pkg::VAL_WIDTH,
    parameter int ADDR_WIDTH = dict_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH = 8,
    parameter int PREFILL    = 8,
    parameter int MAX_RETRY  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [VAL_WIDTH-1:0]  mem_rdata,
    output logic                  dict_write_enable,
    output logic [VAL_WIDTH-1:0]  dict_write_val,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            retry_count
);

    import dict_pkg::*;

    localparam int N  = 1 << KEY_WIDTH;
    localparam int KW = KEY_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TH = (PREFILL < N) ? PREFILL : N;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [KW-1:0]         r_issued;
    logic [KW-1:0]         r_written;
    logic [CW-1:0]         r_outs;
    logic [1:0]            r_retry;
    logic                  r_done;
    logic                  r_error;

    logic                  w_active;
    logic                  w_req;
    logic                  w_xfer;
    logic                  w_rv;
    logic                  w_we;
    logic                  w_start;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic [VAL_WIDTH-1:0]  w_head;

    assign w_active = (r_state == S_FILL) || (r_state == S_BURST);
    assign w_req    = w_active && (r_issued < KW'(N)) && (w_count + r_outs < CW'(FIFO_DEPTH));
    assign w_xfer   = w_req & mem_gnt;
    assign w_rv     = mem_rvalid && (r_outs != '0);
    assign w_we     = (r_state == S_BURST) && !w_empty;
    assign w_start  = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                ((r_state == S_ERROR) && (r_outs == '0)));

    assign mem_req           = w_req;
    assign mem_addr          = r_base + ADDR_WIDTH'(r_issued);
    assign dict_write_enable = w_we;
    assign dict_write_val    = w_we ? w_head : '0;
    assign busy              = w_active || (r_state == S_ABORT);
    assign done              = r_done;
    assign error             = r_error;
    assign retry_count       = r_retry;

    dict_prefetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (VAL_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_flush (!w_active),
        .i_push  (w_active && w_rv),
        .i_din   (mem_rdata),
        .i_pop   (w_we),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // load sequencing plus issue/write/credit counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_issued  <= '0;
            r_written <= '0;
            r_outs    <= '0;
            r_retry   <= '0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_outs <= r_outs + CW'(w_xfer) - CW'(w_rv);
            if (w_xfer) r_issued <= r_issued + 1'b1;
            if (w_we) r_written <= r_written + 1'b1;
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (w_start) begin
                        r_base    <= base_addr;
                        r_done    <= 1'b0;
                        r_error   <= 1'b0;
                        r_retry   <= '0;
                        r_issued  <= '0;
                        r_written <= '0;
                        r_state   <= S_FILL;
                    end
                end
                S_FILL: if (w_count >= CW'(TH)) r_state <= S_BURST;
                S_BURST: begin
                    if (w_empty) begin
                        if (r_retry == 2'(MAX_RETRY)) begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= S_ABORT;
                            r_retry <= r_retry + 1'b1;
                        end
                    end else if (r_written == KW'(N - 1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_ABORT: begin
                    if (r_outs == '0) begin
                        r_issued  <= '0;
                        r_written <= '0;
                        r_state   <= S_FILL;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dict_loader.sv
// tb_dict_loader: memory model with scripted stalls/latency, per-cycle write and credit checks
module tb_dict_loader;

    localparam int N     = 64;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] base_addr;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [11:0] mem_rdata;
    logic        dict_write_enable;
    logic [11:0] dict_write_val;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  retry_count;

    always #5 clk = ~clk;

    dict_loader dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_addr         (base_addr),
        .mem_req           (mem_req),
        .mem_addr          (mem_addr),
        .mem_gnt           (mem_gnt),
        .mem_rvalid        (mem_rvalid),
        .mem_rdata         (mem_rdata),
        .dict_write_enable (dict_write_enable),
        .dict_write_val    (dict_write_val),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .retry_count       (retry_count)
    );

    typedef struct {
        logic [15:0] base;
        int          mode;
        int          nruns;
        int          first;
        int          last;
        logic        done;
        logic        err;
        logic [1:0]  retry;
    } vec_t;

    typedef struct {
        logic [11:0] d;
        int          due;
    } resp_t;

    int          errors = 0;
    int          checks = 0;
    int          mode = 0;
    int          cyc = 0;
    int          iss = 0;
    int          wr = 0;
    int          run_len = 0;
    int          runs[$];
    int          stall_end = 0;
    int          last_due = 0;
    bit          stall_used = 0;
    bit          prev_we = 0;
    logic [15:0] cur_base = 16'h0;
    resp_t       pend[$];
    vec_t        vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " mem_req"}, 32'(mem_req), 0);
        check({tag, " mem_addr"}, 32'(mem_addr), 0);
        check({tag, " we"}, 32'(dict_write_enable), 0);
        check({tag, " wval"}, 32'(dict_write_val), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " error"}, 32'(error), 0);
        check({tag, " retry"}, 32'(retry_count), 0);
    endtask

    task automatic do_start(input logic [15:0] b);
        @(posedge clk);
        #1;
        base_addr  = b;
        cur_base   = b;
        runs.delete();
        iss        = 0;
        wr         = 0;
        run_len    = 0;
        prev_we    = 0;
        stall_used = 0;
        stall_end  = 0;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (!(done || error) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " finished in time"}, 32'(done || error), 1);
        repeat (30) @(negedge clk);
    endtask

    task automatic wait_writes(input int k);
        int n;
        n = 0;
        while (wr < k && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("reach write count", 32'(wr >= k), 1);
    endtask

    // boot memory model and output monitor, all on the falling edge
    initial begin
        logic [15:0] off;
        logic [15:0] ea;
        int          lat;
        int          due;
        bit          g;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                pend.delete();
                mem_rvalid = 1'b0;
                mem_gnt    = 1'b0;
                iss        = 0;
                wr         = 0;
                run_len    = 0;
                prev_we    = 0;
                last_due   = cyc;
                continue;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend[0].d;
                void'(pend.pop_front());
            end else begin
                mem_rvalid = 1'b0;
            end
            off = mem_addr - cur_base;
            g   = 1'b1;
            if (mode == 1) begin
                if (!stall_used && mem_req && off == 16'd30) begin
                    stall_used = 1;
                    stall_end  = cyc + 20;
                end
                g = (cyc >= stall_end);
            end else if (mode == 2) begin
                g = (off < 16'd30);
            end
            mem_gnt = g;
            if (busy && mem_req) check("credit bound", 32'(iss - wr < DEPTH), 1);
            if (done || error) check("no req when finished", 32'(mem_req), 0);
            if (mem_req && mem_gnt) begin
                ea = cur_base + 16'(iss);
                check("req addr", 32'(mem_addr), 32'(ea));
                iss++;
                lat = (mode == 4) ? int'($urandom_range(5, 1)) : 1;
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = due;
                pend.push_back('{mem_addr[11:0], due});
            end
            if (dict_write_enable) begin
                ea = cur_base + 16'(wr);
                check("write value", 32'(dict_write_val), 32'(ea[11:0]));
                wr++;
                run_len++;
            end else if (prev_we) begin
                runs.push_back(run_len);
                run_len = 0;
                if (!done) begin
                    iss = 0;
                    wr  = 0;
                end
            end
            prev_we = dict_write_enable;
        end
    end

    initial begin
        vecs[0] = '{16'h0100, 0, 1, 64, 64, 1'b1, 1'b0, 2'd0};
        vecs[1] = '{16'h0100, 1, 2, 30, 64, 1'b1, 1'b0, 2'd1};
        vecs[2] = '{16'h0100, 2, 4, 30, 30, 1'b0, 1'b1, 2'd3};
        vecs[3] = '{16'hFFF0, 0, 1, 64, 64, 1'b1, 1'b0, 2'd0};
        vecs[4] = '{16'h0040, 4, 1, 64, 64, 1'b1, 1'b0, 2'd0};
        reset     = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        #12;
        check_quiet("reset");
        #5;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mode = vecs[i].mode;
            do_start(vecs[i].base);
            wait_end($sformatf("vec%0d", i));
            check($sformatf("vec%0d runs", i), 32'(runs.size()), 32'(vecs[i].nruns));
            check($sformatf("vec%0d first run", i), runs.size() > 0 ? 32'(runs[0]) : 32'hFFFF, 32'(vecs[i].first));
            check($sformatf("vec%0d last run", i), runs.size() > 0 ? 32'(runs[runs.size()-1]) : 32'hFFFF, 32'(vecs[i].last));
            check($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
            check($sformatf("vec%0d error", i), 32'(error), 32'(vecs[i].err));
            check($sformatf("vec%0d retry", i), 32'(retry_count), 32'(vecs[i].retry));
            check($sformatf("vec%0d busy", i), 32'(busy), 0);
        end
        mode = 0;
        do_start(16'h0100);
        wait_writes(20);
        #2;
        reset = 1'b1;
        #1;
        check_quiet("mid reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_start(16'h0100);
        wait_end("after reset");
        check("after reset runs", 32'(runs.size()), 1);
        check("after reset run len", runs.size() > 0 ? 32'(runs[0]) : 32'hFFFF, 64);
        check("after reset done", 32'(done), 1);
        do_start(16'h0200);
        wait_writes(10);
        @(posedge clk);
        #1;
        base_addr = 16'h0300;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_end("start in burst");
        check("start in burst runs", 32'(runs.size()), 1);
        check("start in burst run len", runs.size() > 0 ? 32'(runs[0]) : 32'hFFFF, 64);
        check("start in burst done", 32'(done), 1);
        check("start in burst retry", 32'(retry_count), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
